// File: rtl/ram512_bist_if.sv
// RAM-side bus between the BIST controller and the ram512 array:
// one write port and two combinational read ports.
interface ram512_bist_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          wr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] d_in;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] d_out_a;
    logic [DW-1:0] d_out_b;

    modport master (
        output wr, wr_addr, d_in, rd_addr_a, rd_addr_b,
        input  d_out_a, d_out_b
    );

    modport slave (
        input  wr, wr_addr, d_in, rd_addr_a, rd_addr_b,
        output d_out_a, d_out_b
    );
endinterface

// File: rtl/ram512_bist.sv
// Built-in self-test controller for ram512. Runs a five-phase march /
// address-uniqueness test (W_BG, RW_INV, R_INV, W_ADDR, R_ADDR), one address
// per cycle, and latches the first mismatch for diagnosis.
module ram512_bist #(
    parameter int            AW    = 9,
    parameter int            DW    = 16,
    parameter int            DEPTH = 512,
    parameter logic [DW-1:0] PAT   = 16'hAAAA
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    ram512_bist_if.master ram,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_exp,
    output logic [DW-1:0] fail_got,
    output logic          fail_port,
    output logic [2:0]    phase
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_BG   = 3'd1,
        RW_INV = 3'd2,
        R_INV  = 3'd3,
        W_ADDR = 3'd4,
        R_ADDR = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state, state_next;
    logic [AW-1:0] cnt, cnt_next, cnt_inc, cnt_dec;

    logic          wr_reg, wr_next;
    logic [AW-1:0] wr_addr_reg, wr_addr_next;
    logic [DW-1:0] d_in_reg, d_in_next;
    logic [AW-1:0] rd_a_reg, rd_a_next;
    logic [AW-1:0] rd_b_reg, rd_b_next;

    logic          busy_next, done_next, pass_next, fail_port_next;
    logic [AW-1:0] fail_addr_next;
    logic [DW-1:0] fail_exp_next, fail_got_next;

    logic          miss;
    logic          miss_port;
    logic [AW-1:0] miss_addr;
    logic [DW-1:0] miss_exp, miss_got;
    logic [DW-1:0] exp_a, exp_b;

    assign cnt_inc = cnt + AW'(1);
    assign cnt_dec = cnt - AW'(1);
    assign exp_a   = DW'(rd_a_reg);
    assign exp_b   = DW'(rd_b_reg);

    assign ram.wr        = wr_reg;
    assign ram.wr_addr   = wr_addr_reg;
    assign ram.d_in      = d_in_reg;
    assign ram.rd_addr_a = rd_a_reg;
    assign ram.rd_addr_b = rd_b_reg;
    assign phase         = state;

    // Next state, next address and next registered outputs; read data is
    // compared against the address currently driven on the read ports.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        wr_next        = wr_reg;
        wr_addr_next   = wr_addr_reg;
        d_in_next      = d_in_reg;
        rd_a_next      = rd_a_reg;
        rd_b_next      = rd_b_reg;
        busy_next      = busy;
        done_next      = done;
        pass_next      = pass;
        fail_addr_next = fail_addr;
        fail_exp_next  = fail_exp;
        fail_got_next  = fail_got;
        fail_port_next = fail_port;
        miss           = 1'b0;
        miss_port      = 1'b0;
        miss_addr      = '0;
        miss_exp       = '0;
        miss_got       = '0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = W_BG;
                    cnt_next       = '0;
                    busy_next      = 1'b1;
                    done_next      = 1'b0;
                    pass_next      = 1'b0;
                    fail_addr_next = '0;
                    fail_exp_next  = '0;
                    fail_got_next  = '0;
                    fail_port_next = 1'b0;
                    wr_next        = 1'b1;
                    wr_addr_next   = '0;
                    d_in_next      = PAT;
                end
            end
            W_BG: begin
                if (cnt == LAST) begin
                    state_next   = RW_INV;
                    cnt_next     = '0;
                    wr_addr_next = '0;
                    d_in_next    = ~PAT;
                    rd_a_next    = '0;
                end else begin
                    cnt_next     = cnt_inc;
                    wr_addr_next = cnt_inc;
                end
            end
            RW_INV: begin
                if (ram.d_out_a != PAT) begin
                    miss      = 1'b1;
                    miss_port = 1'b0;
                    miss_addr = rd_a_reg;
                    miss_exp  = PAT;
                    miss_got  = ram.d_out_a;
                end else if (cnt == LAST) begin
                    state_next = R_INV;
                    cnt_next   = LAST;
                    wr_next    = 1'b0;
                    rd_b_next  = LAST;
                end else begin
                    cnt_next     = cnt_inc;
                    wr_addr_next = cnt_inc;
                    rd_a_next    = cnt_inc;
                end
            end
            R_INV: begin
                if (ram.d_out_b != ~PAT) begin
                    miss      = 1'b1;
                    miss_port = 1'b1;
                    miss_addr = rd_b_reg;
                    miss_exp  = ~PAT;
                    miss_got  = ram.d_out_b;
                end else if (cnt == '0) begin
                    state_next   = W_ADDR;
                    cnt_next     = '0;
                    wr_next      = 1'b1;
                    wr_addr_next = '0;
                    d_in_next    = '0;
                end else begin
                    cnt_next  = cnt_dec;
                    rd_b_next = cnt_dec;
                end
            end
            W_ADDR: begin
                if (cnt == LAST) begin
                    state_next = R_ADDR;
                    cnt_next   = '0;
                    wr_next    = 1'b0;
                    rd_a_next  = '0;
                    rd_b_next  = LAST;
                end else begin
                    cnt_next     = cnt_inc;
                    wr_addr_next = cnt_inc;
                    d_in_next    = DW'(cnt_inc);
                end
            end
            R_ADDR: begin
                if (ram.d_out_a != exp_a) begin
                    miss      = 1'b1;
                    miss_port = 1'b0;
                    miss_addr = rd_a_reg;
                    miss_exp  = exp_a;
                    miss_got  = ram.d_out_a;
                end else if (ram.d_out_b != exp_b) begin
                    miss      = 1'b1;
                    miss_port = 1'b1;
                    miss_addr = rd_b_reg;
                    miss_exp  = exp_b;
                    miss_got  = ram.d_out_b;
                end else if (cnt == LAST) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    pass_next  = 1'b1;
                end else begin
                    cnt_next  = cnt_inc;
                    rd_a_next = cnt_inc;
                    rd_b_next = LAST - cnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase

        // First mismatch ends the run; the DONE state never compares, so only
        // one failure is ever captured per run.
        if (miss) begin
            state_next     = DONE;
            busy_next      = 1'b0;
            done_next      = 1'b1;
            pass_next      = 1'b0;
            wr_next        = 1'b0;
            fail_addr_next = miss_addr;
            fail_exp_next  = miss_exp;
            fail_got_next  = miss_got;
            fail_port_next = miss_port;
        end
    end

    // State, address counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_reg      <= 1'b0;
            wr_addr_reg <= '0;
            d_in_reg    <= '0;
            rd_a_reg    <= '0;
            rd_b_reg    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_exp    <= '0;
            fail_got    <= '0;
            fail_port   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            wr_reg      <= wr_next;
            wr_addr_reg <= wr_addr_next;
            d_in_reg    <= d_in_next;
            rd_a_reg    <= rd_a_next;
            rd_b_reg    <= rd_b_next;
            busy        <= busy_next;
            done        <= done_next;
            pass        <= pass_next;
            fail_addr   <= fail_addr_next;
            fail_exp    <= fail_exp_next;
            fail_got    <= fail_got_next;
            fail_port   <= fail_port_next;
        end
    end

endmodule

// File: tb/tb_ram512_bist.sv
// Bench for ram512_bist: a behavioural RAM with per-port fault masks, a
// step-indexed reference model of the march sequence, a per-cycle compare
// process, and directed plus randomized runs with literal expectations.
module tb_ram512_bist;

    localparam int          AW    = 9;
    localparam int          DW    = 16;
    localparam int          DEPTH = 512;
    localparam logic [15:0] PAT   = 16'hAAAA;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass, fail_port;
    logic [8:0]  fail_addr;
    logic [15:0] fail_exp, fail_got;
    logic [2:0]  phase;

    ram512_bist_if #(.AW(AW), .DW(DW)) ram_if ();

    ram512_bist #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .PAT(PAT)) dut (
        .clk(clk), .reset(reset), .start(start), .ram(ram_if),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
        .fail_port(fail_port), .phase(phase)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write at the edge, combinational read, faults as masks.
    logic [15:0] mem [DEPTH];
    logic [15:0] and_a = '1, or_a = '0, and_b = '1, or_b = '0;
    always @(posedge clk) if (ram_if.wr) mem[ram_if.wr_addr] <= ram_if.d_in;
    assign ram_if.d_out_a = (mem[ram_if.rd_addr_a] & and_a) | or_a;
    assign ram_if.d_out_b = (mem[ram_if.rd_addr_b] & and_b) | or_b;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_k = 0;
    logic [2:0]  m_phase = 0;
    logic        m_busy = 0, m_done = 0, m_pass = 0, m_wr = 0, m_fport = 0;
    logic [8:0]  m_waddr = 0, m_rda = 0, m_rdb = 0, m_faddr = 0;
    logic [15:0] m_din = 0, m_fexp = 0, m_fgot = 0;
    bit          known_a = 1, known_b = 1;

    task automatic model_zero();
        m_k = 0; m_phase = 0; m_busy = 0; m_done = 0; m_pass = 0; m_wr = 0;
        m_fport = 0; m_waddr = 0; m_rda = 0; m_rdb = 0; m_faddr = 0;
        m_din = 0; m_fexp = 0; m_fgot = 0; known_a = 1; known_b = 1;
    endtask

    // Outputs driven for step k of the test (k counts cycles from the start edge).
    task automatic drive_step(input int k);
        int i;
        i = k % DEPTH;
        m_phase = 3'(k / DEPTH + 1);
        case (k / DEPTH)
            0: begin m_wr = 1; m_waddr = 9'(i); m_din = PAT; end
            1: begin m_wr = 1; m_waddr = 9'(i); m_din = ~PAT; m_rda = 9'(i); known_a = 1; end
            2: begin m_wr = 0; m_rdb = 9'(DEPTH - 1 - i); known_b = 1; end
            3: begin m_wr = 1; m_waddr = 9'(i); m_din = 16'(i); end
            default: begin
                m_wr = 0; m_rda = 9'(i); m_rdb = 9'(DEPTH - 1 - i);
                known_a = 1; known_b = 1;
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_zero();
            end else if (m_phase == 0 || m_phase == 6) begin
                if (start) begin
                    m_busy = 1; m_done = 0; m_pass = 0;
                    m_faddr = 0; m_fexp = 0; m_fgot = 0; m_fport = 0;
                    known_a = 0; known_b = 0; m_k = 0;
                    drive_step(0);
                end
            end else begin
                int ph, i;
                bit bad;
                logic [15:0] e, g, e2, g2;
                ph = m_k / DEPTH; i = m_k % DEPTH; bad = 0;
                if (ph == 1) begin
                    e = PAT; g = (e & and_a) | or_a;
                    if (g != e) begin bad = 1; m_faddr = 9'(i); m_fexp = e; m_fgot = g; m_fport = 0; end
                end else if (ph == 2) begin
                    e = ~PAT; g = (e & and_b) | or_b;
                    if (g != e) begin bad = 1; m_faddr = 9'(DEPTH - 1 - i); m_fexp = e; m_fgot = g; m_fport = 1; end
                end else if (ph == 4) begin
                    e = 16'(i); g = (e & and_a) | or_a;
                    e2 = 16'(DEPTH - 1 - i); g2 = (e2 & and_b) | or_b;
                    if (g != e) begin
                        bad = 1; m_faddr = 9'(i); m_fexp = e; m_fgot = g; m_fport = 0;
                    end else if (g2 != e2) begin
                        bad = 1; m_faddr = 9'(DEPTH - 1 - i); m_fexp = e2; m_fgot = g2; m_fport = 1;
                    end
                end
                if (bad) begin
                    m_phase = 6; m_busy = 0; m_done = 1; m_pass = 0; m_wr = 0;
                end else if (m_k == 5 * DEPTH - 1) begin
                    m_phase = 6; m_busy = 0; m_done = 1; m_pass = 1; m_wr = 0;
                end else begin
                    m_k++;
                    drive_step(m_k);
                end
            end
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("phase", 32'(phase), 32'(m_phase));
                check("busy", 32'(busy), 32'(m_busy));
                check("done", 32'(done), 32'(m_done));
                check("pass", 32'(pass), 32'(m_pass));
                check("fail_addr", 32'(fail_addr), 32'(m_faddr));
                check("fail_exp", 32'(fail_exp), 32'(m_fexp));
                check("fail_got", 32'(fail_got), 32'(m_fgot));
                check("fail_port", 32'(fail_port), 32'(m_fport));
                check("wr", 32'(ram_if.wr), 32'(m_wr));
                if (m_wr || m_phase == 0 || m_phase == 6) begin
                    check("wr_addr", 32'(ram_if.wr_addr), 32'(m_waddr));
                    check("d_in", 32'(ram_if.d_in), 32'(m_din));
                end
                if (known_a) check("rd_addr_a", 32'(ram_if.rd_addr_a), 32'(m_rda));
                if (known_b) check("rd_addr_b", 32'(ram_if.rd_addr_b), 32'(m_rdb));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_phase"}, 32'(phase), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_wr"}, 32'(ram_if.wr), 0);
        check({tag, "_wr_addr"}, 32'(ram_if.wr_addr), 0);
        check({tag, "_d_in"}, 32'(ram_if.d_in), 0);
        check({tag, "_rd_addr_a"}, 32'(ram_if.rd_addr_a), 0);
        check({tag, "_rd_addr_b"}, 32'(ram_if.rd_addr_b), 0);
        check({tag, "_fail_fields"}, 32'({fail_addr, fail_exp, fail_got, fail_port} != '0), 0);
    endtask

    // Start pulse covering exactly one rising edge (e0); returns just after
    // the falling edge that follows e0.
    task automatic kick();
        @(negedge clk); #2 start = 1;
        @(negedge clk); #2 start = 0;
    endtask

    // Counts cycles from e0 until done; optional start pokes and early stop.
    task automatic run_wait(input int poke1, input int poke2, input int stop_at, output int n);
        n = 0;
        while (done !== 1'b1 && n < 3000 && !(stop_at != 0 && n == stop_at)) begin
            @(negedge clk);
            n++;
            #2 start = (n == poke1 || n == poke2);
        end
        start = 0;
        if (stop_at == 0) check("done_seen", 32'(done), 1);
    endtask

    task automatic gap(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int n;
        #(800000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_on = 1;
        check_all_zero("reset");
        #2 reset = 1;

        // Clean run with start pulses while busy.
        kick();
        run_wait(100, 2000, 0, n);
        check("clean_cycles", 32'(n), 2560);
        check("clean_pass", 32'(pass), 1);
        check("clean_phase", 32'(phase), 6);
        check("clean_fail_fields", 32'({fail_addr, fail_exp, fail_got, fail_port} != '0), 0);
        check("model_clean_pass", 32'(m_pass), 1);

        // Port A bit 3 stuck at 0.
        and_a = ~16'h0008;
        gap(2);
        kick();
        run_wait(0, 0, 0, n);
        check("fa_cycles", 32'(n), 513);
        check("fa_pass", 32'(pass), 0);
        check("fa_phase", 32'(phase), 6);
        check("fa_addr", 32'(fail_addr), 0);
        check("fa_exp", 32'(fail_exp), 32'h0000_AAAA);
        check("fa_got", 32'(fail_got), 32'h0000_AAA2);
        check("fa_port", 32'(fail_port), 0);
        check("fa_wr", 32'(ram_if.wr), 0);
        check("model_fa_got", 32'(m_fgot), 32'h0000_AAA2);

        // Restart from a failed DONE with a clean RAM.
        and_a = '1;
        kick();
        check("rs_done", 32'(done), 0);
        check("rs_busy", 32'(busy), 1);
        check("rs_phase", 32'(phase), 1);
        check("rs_fail_fields", 32'({fail_addr, fail_exp, fail_got, fail_port} != '0), 0);
        check("rs_wr", 32'(ram_if.wr), 1);
        check("rs_d_in", 32'(ram_if.d_in), 32'h0000_AAAA);
        run_wait(0, 0, 0, n);
        check("rs_cycles", 32'(n), 2560);
        check("rs_pass", 32'(pass), 1);

        // Port B bit 15 stuck at 1.
        or_b = 16'h8000;
        kick();
        run_wait(0, 0, 0, n);
        check("fb_cycles", 32'(n), 1025);
        check("fb_pass", 32'(pass), 0);
        check("fb_addr", 32'(fail_addr), 511);
        check("fb_exp", 32'(fail_exp), 32'h0000_5555);
        check("fb_got", 32'(fail_got), 32'h0000_D555);
        check("fb_port", 32'(fail_port), 1);
        check("model_fb_addr", 32'(m_faddr), 511);
        or_b = '0;

        // Reset mid-run, then a full run after release.
        kick();
        run_wait(0, 0, 700, n);
        check("mid_cycles", 32'(n), 700);
        reset = 0;
        #1 check_all_zero("midreset");
        gap(2);
        #2 reset = 1;
        kick();
        run_wait(0, 0, 0, n);
        check("post_reset_cycles", 32'(n), 2560);
        check("post_reset_pass", 32'(pass), 1);

        // Randomized single-bit stuck faults, gaps and stray start pulses.
        for (int r = 0; r < 4; r++) begin
            int sel, b, sv;
            logic [15:0] bm;
            sel = $urandom_range(0, 2);
            b = $urandom_range(0, 15);
            sv = $urandom_range(0, 1);
            bm = 16'h0001 << b;
            and_a = '1; or_a = '0; and_b = '1; or_b = '0;
            if (sel == 0) begin if (sv != 0) or_a = bm; else and_a = ~bm; end
            if (sel == 1) begin if (sv != 0) or_b = bm; else and_b = ~bm; end
            gap($urandom_range(1, 6));
            kick();
            run_wait($urandom_range(1, 2500), 0, 0, n);
            check("rand_pass", 32'(pass), 32'(m_pass));
        end
        and_a = '1; or_a = '0; and_b = '1; or_b = '0;
        gap(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
